// File: rtl/pipeline_pkg.sv
// Shared RV64 load/store funct3 encodings and access-size helpers.
// The forwarding and hazard units reuse these.
package pipeline_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  // Low index bits that must be zero for an access of the given size code.
  function automatic logic [2:0] align_mask(input logic [1:0] size_code);
    case (size_code)
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  endfunction

  function automatic logic [7:0] byte_mask(input logic [1:0] size_code);
    case (size_code)
      2'd0:    byte_mask = 8'h01;
      2'd1:    byte_mask = 8'h03;
      2'd2:    byte_mask = 8'h0F;
      default: byte_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of a little-endian 64-bit slice according to load funct3.
module load_extend
  import pipeline_pkg::*;
(
  input  logic [63:0] raw,
  input  logic [2:0]  funct3,
  output logic [63:0] data
);

  always_comb begin
    data = '0;
    case (funct3)
      F3_LB:   data = {{56{raw[7]}},  raw[7:0]};
      F3_LH:   data = {{48{raw[15]}}, raw[15:0]};
      F3_LW:   data = {{32{raw[31]}}, raw[31:0]};
      F3_LD:   data = raw;
      F3_LBU:  data = {56'h0, raw[7:0]};
      F3_LHU:  data = {48'h0, raw[15:0]};
      F3_LWU:  data = {32'h0, raw[31:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_unit.sv
// MEM-stage data memory: byte-addressed little-endian array with RV64 sizing,
// combinational read-before-write loads, misalignment detect and sticky fault.
module data_memory_unit
  import pipeline_pkg::*;
#(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_MemWrite,
  input  logic [2:0]  EX_MEM_funct3,
  input  logic [63:0] EX_MEM_ALU_Out,
  input  logic [63:0] EX_MEM_Write_Data,
  output logic [63:0] Read_Data,
  output logic        Misaligned,
  output logic        Mem_Fault,
  output logic [31:0] Store_Count
);

  logic [7:0]           mem [MEM_BYTES];
  logic [ADDR_BITS-1:0] idx;
  logic                 access;
  logic                 illegal;
  logic                 unaligned;
  logic                 do_store;
  logic [7:0]           wmask;
  logic [63:0]          raw;
  logic [63:0]          ext;
  logic                 unused_addr_hi;

  // Upper address bits are ignored so addresses wrap modulo MEM_BYTES.
  assign idx            = EX_MEM_ALU_Out[ADDR_BITS-1:0];
  assign unused_addr_hi = ^EX_MEM_ALU_Out[63:ADDR_BITS];

  always_comb begin
    access    = EX_MEM_MemRead | EX_MEM_MemWrite;
    // A store's encoding takes precedence when both requests are high.
    illegal   = EX_MEM_MemWrite ? EX_MEM_funct3[2] : (EX_MEM_funct3 == 3'b111);
    unaligned = |(idx[2:0] & align_mask(EX_MEM_funct3[1:0]));
    Misaligned = access & (illegal | unaligned);
    do_store  = EX_MEM_MemWrite & ~Misaligned & ~reset;
    wmask     = byte_mask(EX_MEM_funct3[1:0]);
  end

  always_comb begin
    raw = '0;
    for (int k = 0; k < 8; k++) begin
      raw[8*k +: 8] = mem[idx + ADDR_BITS'(k)];
    end
  end

  load_extend u_load_extend (
    .raw    (raw),
    .funct3 (EX_MEM_funct3),
    .data   (ext)
  );

  assign Read_Data = (EX_MEM_MemRead & ~Misaligned & ~reset) ? ext : 64'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        mem[i] <= 8'h00;
      end
      Mem_Fault   <= 1'b0;
      Store_Count <= 32'h0;
    end else begin
      if (Misaligned) begin
        Mem_Fault <= 1'b1;
      end
      if (do_store) begin
        for (int k = 0; k < 8; k++) begin
          if (wmask[k]) begin
            mem[idx + ADDR_BITS'(k)] <= EX_MEM_Write_Data[8*k +: 8];
          end
        end
        if (Store_Count != 32'hFFFF_FFFF) begin
          Store_Count <= Store_Count + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed scoreboard bench for data_memory_unit: expectations queued as each
// step is driven, then popped and compared once the DUT output has settled.
module tb_data_memory_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd;
  logic        wr;
  logic [2:0]  f3;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] read_data;
  logic        misaligned;
  logic        mem_fault;
  logic [31:0] store_count;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  data_memory_unit #(.MEM_BYTES(256), .ADDR_BITS(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .EX_MEM_MemRead    (rd),
    .EX_MEM_MemWrite   (wr),
    .EX_MEM_funct3     (f3),
    .EX_MEM_ALU_Out    (addr),
    .EX_MEM_Write_Data (wdata),
    .Read_Data         (read_data),
    .Misaligned        (misaligned),
    .Mem_Fault         (mem_fault),
    .Store_Count       (store_count)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // Drive one access away from the rising edge, then let combinational outputs settle.
  task automatic drive(input logic r, input logic w, input logic [2:0] fn,
                       input logic [63:0] a, input logic [63:0] d);
    @(negedge clk);
    rd = r; wr = w; f3 = fn; addr = a; wdata = d;
    #1;
  endtask

  task automatic load_chk(input string tag, input logic [2:0] fn,
                          input logic [63:0] a, input logic [63:0] exp);
    drive(1'b1, 1'b0, fn, a, 64'h0);
    push(tag, exp);
    chk(read_data);
  endtask

  initial begin
    reset = 1'b1; rd = 1'b0; wr = 1'b0; f3 = 3'b0; addr = '0; wdata = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    push("reset_fault", 64'h0);         chk({63'h0, mem_fault});
    push("reset_count", 64'h0);         chk({32'h0, store_count});
    push("reset_read", 64'h0);          chk(read_data);

    drive(1'b0, 1'b1, 3'b011, 64'h10, 64'h8877_6655_4433_2211);
    push("sd_aligned_mis", 64'h0);      chk({63'h0, misaligned});

    load_chk("ld_0x10",  3'b011, 64'h10, 64'h8877_6655_4433_2211);
    push("count_after_sd", 64'd1);      chk({32'h0, store_count});
    load_chk("lb_0x17",  3'b000, 64'h17, 64'hFFFF_FFFF_FFFF_FF88);
    load_chk("lbu_0x17", 3'b100, 64'h17, 64'h88);
    load_chk("lh_0x16",  3'b001, 64'h16, 64'hFFFF_FFFF_FFFF_8877);
    load_chk("lwu_0x14", 3'b110, 64'h14, 64'h0000_0000_8877_6655);
    load_chk("lw_0x14",  3'b010, 64'h14, 64'hFFFF_FFFF_8877_6655);
    load_chk("lhu_0x10", 3'b101, 64'h10, 64'h2211);

    drive(1'b0, 1'b1, 3'b010, 64'h13, 64'hDEAD_BEEF);
    push("sw_0x13_mis", 64'h1);         chk({63'h0, misaligned});
    push("fault_before_edge", 64'h0);   chk({63'h0, mem_fault});
    drive(1'b0, 1'b0, 3'b000, 64'h0, 64'h0);
    push("idle_read", 64'h0);           chk(read_data);
    push("idle_mis", 64'h0);            chk({63'h0, misaligned});
    push("fault_set", 64'h1);           chk({63'h0, mem_fault});
    push("count_unchanged", 64'd1);     chk({32'h0, store_count});
    load_chk("ld_0x10_after_bad_sw", 3'b011, 64'h10, 64'h8877_6655_4433_2211);
    push("fault_held", 64'h1);          chk({63'h0, mem_fault});

    load_chk("ld_wrap", 3'b011, 64'h1_0000_0010, 64'h8877_6655_4433_2211);
    drive(1'b0, 1'b1, 3'b000, 64'hFF, 64'h1234_56AA);
    load_chk("lbu_0xff", 3'b100, 64'hFF, 64'hAA);
    push("count_after_sb", 64'd2);      chk({32'h0, store_count});
    load_chk("lbu_0xfe_untouched", 3'b100, 64'hFE, 64'h0);

    drive(1'b0, 1'b1, 3'b011, 64'h20, 64'h5);
    drive(1'b1, 1'b1, 3'b011, 64'h20, 64'h1);
    push("rbw_read", 64'h5);            chk(read_data);
    load_chk("ld_0x20_after_rbw", 3'b011, 64'h20, 64'h1);
    push("count_after_rbw", 64'd4);     chk({32'h0, store_count});

    drive(1'b0, 1'b1, 3'b100, 64'h40, 64'hFF);
    push("store_f3_illegal", 64'h1);    chk({63'h0, misaligned});
    drive(1'b1, 1'b0, 3'b111, 64'h40, 64'h0);
    push("load_f3_111_mis", 64'h1);     chk({63'h0, misaligned});
    push("load_f3_111_read", 64'h0);    chk(read_data);
    drive(1'b1, 1'b0, 3'b001, 64'h11, 64'h0);
    push("lh_0x11_mis", 64'h1);         chk({63'h0, misaligned});
    push("lh_0x11_read", 64'h0);        chk(read_data);
    load_chk("lbu_0x40_untouched", 3'b100, 64'h40, 64'h0);
    push("count_after_illegal", 64'd4); chk({32'h0, store_count});

    drive(1'b0, 1'b1, 3'b011, 64'h30, 64'h1234);
    load_chk("ld_0x30_pre", 3'b011, 64'h30, 64'h1234);
    @(negedge clk);
    reset = 1'b1; rd = 1'b1; wr = 1'b1; f3 = 3'b011; addr = 64'h30; wdata = 64'h9999;
    #1;
    push("reset_read_zero", 64'h0);     chk(read_data);
    push("reset_mis_inputs", 64'h0);    chk({63'h0, misaligned});
    @(negedge clk);
    reset = 1'b0; rd = 1'b0; wr = 1'b0;
    #1;
    push("post_reset_fault", 64'h0);    chk({63'h0, mem_fault});
    push("post_reset_count", 64'h0);    chk({32'h0, store_count});
    load_chk("post_reset_0x30", 3'b011, 64'h30, 64'h0);
    load_chk("post_reset_0x10", 3'b011, 64'h10, 64'h0);
    load_chk("post_reset_0xff", 3'b100, 64'hFF, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_memory_unit.md
Name: data_memory_unit

Overview:
- MEM-stage data memory of the hazard-controlled 64-bit RISC-V pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB register. Its Read_Data output is latched by MEM/WB in the same cycle it is produced.
- Provides a byte-addressable, little-endian array with RV64 load/store sizing, sign/zero extension, misalignment detection and a sticky fault flag.

Parameters:
- MEM_BYTES, 256, array size in bytes; power of two, at least 8.
- ADDR_BITS, 8, log2(MEM_BYTES); selects the index bits of the address.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- EX_MEM_MemRead  input  1  load request this cycle.
- EX_MEM_MemWrite  input  1  store request this cycle.
- EX_MEM_funct3  input  3  access size/sign code.
- EX_MEM_ALU_Out  input  64  byte address.
- EX_MEM_Write_Data  input  64  store data; low bytes are used.
- Read_Data  output  64  extended load result (combinational).
- Misaligned  output  1  current access is misaligned or illegal (combinational).
- Mem_Fault  output  1  sticky fault flag (registered).
- Store_Count  output  32  number of stores performed (registered).

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Address handling:
  - Index = EX_MEM_ALU_Out[ADDR_BITS-1:0]; upper address bits are ignored, so addresses wrap modulo MEM_BYTES.
  - Byte order is little-endian: byte at index holds bits [7:0].
- Load sizes (funct3):
  - 000 lb, 001 lh, 010 lw, 011 ld are sign-extended.
  - 100 lbu, 101 lhu, 110 lwu are zero-extended.
  - 111 is illegal.
- Store sizes: funct3 000 sb, 001 sh, 010 sw, 011 sd; any funct3[2]=1 on a store is illegal.
- Alignment and legality:
  - An access is misaligned when the index is not a multiple of its size (2/4/8 bytes).
  - Misaligned = (MemRead|MemWrite) & (misaligned | illegal).
  - Aligned accesses never straddle the array end.
- Reads:
  - Combinational, zero added latency.
  - Read_Data = extended value when MemRead=1, Misaligned=0 and reset=0; otherwise 64'h0.
- Writes:
  - On the rising edge, when MemWrite=1, Misaligned=0 and reset=0, the addressed 1/2/4/8 bytes take EX_MEM_Write_Data[8*size-1:0].
  - Other bytes are unchanged.
  - Suppressed (misaligned/illegal) stores leave the array untouched.
- MemRead and MemWrite both high:
  - The store is performed.
  - Read_Data shows the pre-edge contents (read-before-write).
  - Misalignment/legality uses the store encoding.
- Mem_Fault:
  - Set at the edge when Misaligned=1.
  - Held until reset; reset wins over a simultaneous fault.
- Store_Count:
  - Increments by 1 at each edge with a performed store.
  - Saturates at 32'hFFFF_FFFF; no wrap.
- Reset (sampled at the edge, may arrive mid-operation):
  - All MEM_BYTES bytes cleared to 0; Mem_Fault=0; Store_Count=0.
  - A store presented in the same cycle is discarded.
  - While reset=1, Read_Data=0 and Misaligned still reflects the inputs.
- Stall/flush are handled upstream: a bubble arrives as MemRead=MemWrite=0. Such a cycle has no side effects, and Read_Data=0.

Decomposition:
- Shared package pipeline_pkg holds the funct3 load/store encodings (LB..LWU, SB..SD) and the size-decode helper constants; these are reused by the forwarding and hazard units.
- One natural sub-module, load_extend: combinational; takes the raw 64-bit little-endian word slice plus funct3 and produces the extended Read_Data. It is also reusable for a future unaligned-trap handler.

Test Plan:
- Reset, then sd 64'h8877_6655_4433_2211 at address 0x10, then ld 0x10 -> Read_Data=64'h8877665544332211; Store_Count=1.
- Following the previous store: lb 0x17 -> 64'hFFFF_FFFF_FFFF_FF88; lbu 0x17 -> 64'h88; lh 0x16 -> 64'hFFFF_FFFF_FFFF_8877; lwu 0x14 -> 64'h0000_0000_8877_6655.
- sw 64'hDEADBEEF at 0x13 (misaligned) -> Misaligned=1 that cycle; memory at 0x10..0x17 unchanged; Mem_Fault=1 after the edge and held; Store_Count unchanged.
- Load at address 0x1_0000_0010 with MEM_BYTES=256 -> same data as 0x10 (wrap). sb 8'hAA at 0xFF then lbu 0xFF -> 64'hAA.
- MemRead=MemWrite=1, sd 64'h1 at 0x20 holding 64'h5 -> Read_Data=5 in that cycle; ld 0x20 on the next cycle -> 1.
- Reset asserted for one edge concurrent with sd at 0x30 -> after the edge all reads return 0, Mem_Fault=0, Store_Count=0, and address 0x30 reads 0.
